// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: W-bit words enter a DEPTH-entry FIFO over
// valid/ready and leave one bit per clock on ser_out, gapless across words.
module bit_serializer #(
    parameter int W         = 8,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         ser_out,
    output logic         ser_active,
    output logic         busy
);

    localparam int CW = $clog2(W);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(W-1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state, state_nx;
    logic [W-1:0]   mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [PW:0]    count;
    logic [W-1:0]   shreg;
    logic [W-1:0]   head;
    logic [CW-1:0]  cnt;
    logic           push, load;

    // Handshake: a word transfers on a rising edge where in_valid && in_ready.
    // in_ready depends only on the registered occupancy, never on a same-edge pop.
    assign in_ready = (count != FULL_CNT);
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];
    assign busy     = (count != '0) || (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // A load pops the FIFO head; at the end of a word the next one is taken
    // on the same edge so the serial stream has no gap.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == '0) begin
                    if (count != '0) load     = 1'b1;
                    else             state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (load) rd_ptr <= rd_ptr + PW'(1);
            case ({push, load})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // The first bit goes straight to ser_out on load; shreg keeps the rest
    // aligned so the outgoing bit is always at the same end.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            cnt        <= '0;
            ser_out    <= 1'b0;
            ser_active <= 1'b0;
        end else if (load) begin
            cnt        <= LAST_CNT;
            ser_active <= 1'b1;
            if (MSB_FIRST) begin
                ser_out <= head[W-1];
                shreg   <= {head[W-2:0], 1'b0};
            end else begin
                ser_out <= head[0];
                shreg   <= {1'b0, head[W-1:1]};
            end
        end else if (state == SHIFT && cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (MSB_FIRST) begin
                ser_out <= shreg[W-1];
                shreg   <= {shreg[W-2:0], 1'b0};
            end else begin
                ser_out <= shreg[0];
                shreg   <= {1'b0, shreg[W-1:1]};
            end
        end else begin
            ser_out    <= 1'b0;
            ser_active <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first and an LSB-first instance share one
// stimulus stream and are checked against a timeline model of the bit stream.
module tb_bit_serializer;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    typedef struct {
        int   edge_n;
        logic bit_m;
        logic bit_l;
    } exp_bit_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready_m, ser_out_m, ser_active_m, busy_m;
    logic         in_ready_l, ser_out_l, ser_active_l, busy_l;

    int       n_cmp = 0;
    int       n_err = 0;
    int       cyc = 0;
    int       last_pop = -1000;
    bit       started = 1'b0;
    exp_bit_t exp_q[$];
    int       pend_q[$];

    always #5 clk = ~clk;

    bit_serializer #(.W(W), .DEPTH(DEPTH), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_m), .ser_out(ser_out_m), .ser_active(ser_active_m), .busy(busy_m)
    );

    bit_serializer #(.W(W), .DEPTH(DEPTH), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_l), .ser_out(ser_out_l), .ser_active(ser_active_l), .busy(busy_l)
    );

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // Reference model: every accepted word owns W consecutive output cycles,
    // starting one edge after acceptance or right after the previous word ends.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            pend_q.delete();
            last_pop = -1000;
            started  = 1'b1;
        end else if (in_valid && in_ready_m) begin
            int p;
            p = (cyc + 1 > last_pop + W) ? cyc + 1 : last_pop + W;
            last_pop = p;
            pend_q.push_back(p);
            for (int k = 0; k < W; k++)
                exp_q.push_back('{p + k, in_data[W-1-k], in_data[k]});
        end
    end

    // Monitor: compares every output of both instances each cycle.
    always @(negedge clk) begin
        if (started) begin
            logic e_act, e_m, e_l, e_busy, e_rdy;
            while (pend_q.size() > 0 && pend_q[0] <= cyc) void'(pend_q.pop_front());
            e_busy = (exp_q.size() != 0);
            e_rdy  = (pend_q.size() < DEPTH);
            if (exp_q.size() > 0 && exp_q[0].edge_n == cyc) begin
                e_act = 1'b1;
                e_m   = exp_q[0].bit_m;
                e_l   = exp_q[0].bit_l;
                void'(exp_q.pop_front());
            end else begin
                e_act = 1'b0;
                e_m   = 1'b0;
                e_l   = 1'b0;
            end
            check("ser_active_msb", ser_active_m, e_act);
            check("ser_active_lsb", ser_active_l, e_act);
            check("ser_out_msb", ser_out_m, e_m);
            check("ser_out_lsb", ser_out_l, e_l);
            check("busy_msb", busy_m, e_busy);
            check("busy_lsb", busy_l, e_busy);
            check("in_ready_msb", in_ready_m, e_rdy);
            check("in_ready_lsb", in_ready_l, e_rdy);
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge,
    // leaving in_valid high so back-to-back calls stream without a gap.
    task automatic send(input logic [W-1:0] w);
        int guard;
        in_data  = w;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready_m && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout at cycle %0d: in_ready stuck low, required high", cyc);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int t1;
        @(negedge clk);
        do_reset();

        send(8'hB0);
        idle(12);

        send(8'hA5);
        send(8'h3C);
        idle(20);

        do_reset();
        for (int i = 1; i <= 5; i++) send(W'(i));
        n_cmp++;
        if (in_ready_m !== 1'b0) begin
            n_err++;
            $display("FAIL fill_capacity at cycle %0d: in_ready %b after 5 words, required 0", cyc, in_ready_m);
        end
        send(8'h06);
        idle(60);

        send(8'h0D);
        idle(12);

        send(8'hFF);
        send(8'hFF);
        t1 = cyc;
        in_valid = 1'b0;
        while (cyc < t1 + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(20);

        send(8'h96);
        t1 = cyc;
        send(8'h5A);
        in_valid = 1'b0;
        while (cyc < t1 + W) @(negedge clk);
        send(8'hC3);
        idle(30);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
            if ($urandom_range(0, 7) == 0) begin
                in_data  = W'($urandom);
                in_valid = 1'b1;
                @(negedge clk);
                in_valid = 1'b0;
            end else begin
                send(W'($urandom));
            end
        end
        idle(60);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain at cycle %0d: %0d bits still expected, required 0", cyc, exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
